// File: rtl/vec_operand_collector.sv
// Operand collector: fetches the vs1/vs2 register groups (1, 2 or 4 regs) from the VRF and presents them as 4xVLEN buses.
// Optional scalar-broadcast operand for vs1 when VEC_OPC_VX_BCAST_EN is defined.
module vec_operand_collector #(
  parameter int VLEN_BITS = 128,
  parameter int VREG_AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [VREG_AW-1:0]       req_vs1,
  input  logic [VREG_AW-1:0]       req_vs2,
  input  logic [VREG_AW-1:0]       req_vd,
  input  logic [1:0]               req_lmul,
  input  logic                     req_sew,
`ifdef VEC_OPC_VX_BCAST_EN
  input  logic                     req_vx,
  input  logic [31:0]              req_rs1,
`endif
  output logic                     vrf_rd_en,
  output logic [VREG_AW-1:0]       vrf_rd_addr1,
  output logic [VREG_AW-1:0]       vrf_rd_addr2,
  input  logic [VLEN_BITS-1:0]     vrf_rd_data1,
  input  logic [VLEN_BITS-1:0]     vrf_rd_data2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*VLEN_BITS-1:0]   out_vs1_bus,
  output logic [4*VLEN_BITS-1:0]   out_vs2_bus,
  output logic [VREG_AW-1:0]       out_vd,
  output logic [2:0]               out_nregs,
  output logic                     out_sew
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic                     req_ready_q, req_ready_d;
  logic                     rd_en_q, rd_en_d;
  logic [VREG_AW-1:0]       addr1_q, addr1_d;
  logic [VREG_AW-1:0]       addr2_q, addr2_d;
  logic [1:0]               k_q, k_d;
  logic [2:0]               n_q, n_d;
  logic [VREG_AW-1:0]       vs1_q, vs1_d;
  logic [VREG_AW-1:0]       vs2_q, vs2_d;
  logic [VREG_AW-1:0]       vd_q, vd_d;
  logic                     sew_q, sew_d;
  logic                     out_valid_q, out_valid_d;
  logic [4*VLEN_BITS-1:0]   bus1_q, bus1_d;
  logic [4*VLEN_BITS-1:0]   bus2_q, bus2_d;
  logic                     cap_vld_q, cap_vld_d;
  logic [1:0]               cap_idx_q, cap_idx_d;
  logic                     use_vx;

  function automatic logic [2:0] lmul_to_n(input logic [1:0] lmul);
    case (lmul)
      2'b01:   lmul_to_n = 3'd2;
      2'b10:   lmul_to_n = 3'd4;
      default: lmul_to_n = 3'd1;
    endcase
  endfunction

`ifdef VEC_OPC_VX_BCAST_EN
  logic        vx_q, vx_d;
  logic [31:0] rs1_q, rs1_d;
  assign use_vx = vx_q;

  // Scalar replicated across each of the first n slices, width set by SEW.
  function automatic logic [4*VLEN_BITS-1:0] bcast(input logic [31:0] rs1, input logic sew,
                                                   input logic [2:0] n);
    logic [VLEN_BITS-1:0] s;
    bcast = '0;
    s = sew ? {(VLEN_BITS/32){rs1}} : {(VLEN_BITS/8){rs1[7:0]}};
    for (int i = 0; i < 4; i++)
      if (i < int'(n)) bcast[i*VLEN_BITS +: VLEN_BITS] = s;
  endfunction
`else
  assign use_vx = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rd_en_d     = rd_en_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    k_d         = k_q;
    n_d         = n_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    vd_d        = vd_q;
    sew_d       = sew_q;
    out_valid_d = out_valid_q;
    bus1_d      = bus1_q;
    bus2_d      = bus2_q;
`ifdef VEC_OPC_VX_BCAST_EN
    vx_d        = vx_q;
    rs1_d       = rs1_q;
`endif
    // A read issued last cycle returns data now; remember which slice it belongs to.
    cap_vld_d = rd_en_q;
    cap_idx_d = k_q;
    if (cap_vld_q) begin
      bus2_d[int'(cap_idx_q)*VLEN_BITS +: VLEN_BITS] = vrf_rd_data2;
      if (!use_vx)
        bus1_d[int'(cap_idx_q)*VLEN_BITS +: VLEN_BITS] = vrf_rd_data1;
    end

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          vs1_d       = req_vs1;
          vs2_d       = req_vs2;
          vd_d        = req_vd;
          sew_d       = req_sew;
          n_d         = lmul_to_n(req_lmul);
          k_d         = 2'd0;
          req_ready_d = 1'b0;
          rd_en_d     = 1'b1;
          addr1_d     = req_vs1;
          addr2_d     = req_vs2;
          bus1_d      = '0;
          bus2_d      = '0;
`ifdef VEC_OPC_VX_BCAST_EN
          vx_d  = req_vx;
          rs1_d = req_rs1;
          if (req_vx) begin
            addr1_d = '0;
            bus1_d  = bcast(req_rs1, req_sew, lmul_to_n(req_lmul));
          end
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if ({1'b0, k_q} == n_q - 3'd1) begin
          rd_en_d = 1'b0;
          addr1_d = '0;
          addr2_d = '0;
          state_d = S_LAST;
        end else begin
          k_d     = k_q + 2'd1;
          addr1_d = use_vx ? '0 : vs1_q + VREG_AW'(k_q + 2'd1);
          addr2_d = vs2_q + VREG_AW'(k_q + 2'd1);
        end
      end
      S_LAST: begin
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      k_q         <= '0;
      n_q         <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vd_q        <= '0;
      sew_q       <= 1'b0;
      out_valid_q <= 1'b0;
      bus1_q      <= '0;
      bus2_q      <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
`ifdef VEC_OPC_VX_BCAST_EN
      vx_q        <= 1'b0;
      rs1_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rd_en_q     <= rd_en_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      k_q         <= k_d;
      n_q         <= n_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      vd_q        <= vd_d;
      sew_q       <= sew_d;
      out_valid_q <= out_valid_d;
      bus1_q      <= bus1_d;
      bus2_q      <= bus2_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
`ifdef VEC_OPC_VX_BCAST_EN
      vx_q        <= vx_d;
      rs1_q       <= rs1_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign vrf_rd_en    = rd_en_q;
  assign vrf_rd_addr1 = addr1_q;
  assign vrf_rd_addr2 = addr2_q;
  assign out_valid    = out_valid_q;
  assign out_vs1_bus  = bus1_q;
  assign out_vs2_bus  = bus2_q;
  assign out_vd       = vd_q;
  assign out_nregs    = n_q;
  assign out_sew      = sew_q;

endmodule

// File: tb/tb_vec_operand_collector.sv
// Self-checking bench for vec_operand_collector: synchronous VRF model plus a group-level reference for latency, addresses and payload.
module tb_vec_operand_collector;

  localparam int VL = 128;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [4:0]     req_vs1 = '0, req_vs2 = '0, req_vd = '0;
  logic [1:0]     req_lmul = '0;
  logic           req_sew = 1'b0;
  logic           req_vx = 1'b0;
  logic [31:0]    req_rs1 = '0;
  logic           vrf_rd_en;
  logic [4:0]     vrf_rd_addr1, vrf_rd_addr2;
  logic [VL-1:0]  vrf_rd_data1 = '0, vrf_rd_data2 = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [4*VL-1:0] out_vs1_bus, out_vs2_bus;
  logic [4:0]     out_vd;
  logic [2:0]     out_nregs;
  logic           out_sew;

  int tests = 0;
  int fails = 0;
  logic [VL-1:0] mem [32];

  vec_operand_collector #(.VLEN_BITS(VL), .VREG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .req_lmul(req_lmul), .req_sew(req_sew),
`ifdef VEC_OPC_VX_BCAST_EN
    .req_vx(req_vx), .req_rs1(req_rs1),
`endif
    .vrf_rd_en(vrf_rd_en), .vrf_rd_addr1(vrf_rd_addr1), .vrf_rd_addr2(vrf_rd_addr2),
    .vrf_rd_data1(vrf_rd_data1), .vrf_rd_data2(vrf_rd_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vs1_bus(out_vs1_bus), .out_vs2_bus(out_vs2_bus),
    .out_vd(out_vd), .out_nregs(out_nregs), .out_sew(out_sew)
  );

  always #5 clk = ~clk;

  // VRF: synchronous read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (vrf_rd_en) begin
      vrf_rd_data1 <= mem[vrf_rd_addr1];
      vrf_rd_data2 <= mem[vrf_rd_addr2];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4*VL-1:0] obs, input logic [4*VL-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nregs_of(input logic [1:0] lmul);
    if (lmul == 2'b01) return 2;
    if (lmul == 2'b10) return 4;
    return 1;
  endfunction

  // Reference group: register (base+k) mod 32 in slice k for k<n, zero above.
  function automatic logic [4*VL-1:0] group_of(input int base, input int n);
    logic [4*VL-1:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[k*VL +: VL] = mem[(base + k) % 32];
    return b;
  endfunction

  function automatic logic [4*VL-1:0] scalar_group(input logic [31:0] rs1, input logic sew, input int n);
    logic [4*VL-1:0] b;
    b = '0;
    for (int k = 0; k < n; k++)
      for (int byte_i = 0; byte_i < VL/8; byte_i++)
        b[k*VL + byte_i*8 +: 8] = sew ? rs1[(byte_i % 4)*8 +: 8] : rs1[7:0];
    return b;
  endfunction

  task automatic run_txn(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                         input logic [1:0] lmul, input logic sew, input logic vx,
                         input logic [31:0] rs1, input int hold);
    int n;
    logic [4*VL-1:0] e1, e2;
    n  = nregs_of(lmul);
    e1 = vx ? scalar_group(rs1, sew, n) : group_of(int'(vs1), n);
    e2 = group_of(int'(vs2), n);
    chk("idle_req_ready", 512'(req_ready), 512'(1));
    req_valid = 1'b1; req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    req_lmul = lmul; req_sew = sew; req_vx = vx; req_rs1 = rs1;
    step();
    req_valid = 1'b0;
    req_vs1 = 5'($urandom); req_vs2 = 5'($urandom); req_vd = 5'($urandom);
    req_lmul = 2'($urandom); req_sew = 1'($urandom); req_rs1 = $urandom;
    for (int c = 0; c < n; c++) begin
      chk("fetch_rd_en", 512'(vrf_rd_en), 512'(1));
      chk("fetch_addr1", 512'(vrf_rd_addr1), vx ? 512'(0) : 512'((int'(vs1) + c) % 32));
      chk("fetch_addr2", 512'(vrf_rd_addr2), 512'((int'(vs2) + c) % 32));
      chk("fetch_out_valid", 512'(out_valid), 512'(0));
      chk("fetch_req_ready", 512'(req_ready), 512'(0));
      step();
    end
    chk("last_rd_en", 512'(vrf_rd_en), 512'(0));
    chk("last_out_valid", 512'(out_valid), 512'(0));
    step();
    chk("hold_out_valid", 512'(out_valid), 512'(1));
    chk("vs1_bus", out_vs1_bus, e1);
    chk("vs2_bus", out_vs2_bus, e2);
    chk("out_vd", 512'(out_vd), 512'(vd));
    chk("out_nregs", 512'(out_nregs), 512'(n));
    chk("out_sew", 512'(out_sew), 512'(sew));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom);
      step();
      chk("stall_out_valid", 512'(out_valid), 512'(1));
      chk("stall_vs1_bus", out_vs1_bus, e1);
      chk("stall_vs2_bus", out_vs2_bus, e2);
      chk("stall_req_ready", 512'(req_ready), 512'(0));
      chk("stall_rd_en", 512'(vrf_rd_en), 512'(0));
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("done_out_valid", 512'(out_valid), 512'(0));
    chk("done_req_ready", 512'(req_ready), 512'(1));
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};

    // Reset state, then release away from the clock edge
    #12;
    chk("rst_req_ready", 512'(req_ready), 512'(0));
    chk("rst_rd_en", 512'(vrf_rd_en), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_vs1_bus", out_vs1_bus, 512'(0));
    chk("rst_vs2_bus", out_vs2_bus, 512'(0));
    #11 rst_n = 1'b1;
    step();
    chk("post_rst_req_ready", 512'(req_ready), 512'(1));

    run_txn(5'd3, 5'd5, 5'd7, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    run_txn(5'd8, 5'd30, 5'd1, 2'b10, 1'b1, 1'b0, 32'd0, 0);
    run_txn(5'd12, 5'd12, 5'd2, 2'b01, 1'b0, 1'b0, 32'd0, 5);
    run_txn(5'd31, 5'd4, 5'd9, 2'b11, 1'b1, 1'b0, 32'd0, 1);

    // Reset asserted during the second fetch cycle of an lmul=4 request
    chk("pre_abort_req_ready", 512'(req_ready), 512'(1));
    req_valid = 1'b1; req_vs1 = 5'd20; req_vs2 = 5'd21; req_lmul = 2'b10; req_sew = 1'b0; req_vx = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("abort_in_fetch", 512'(vrf_rd_en), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_en", 512'(vrf_rd_en), 512'(0));
    chk("abort_req_ready", 512'(req_ready), 512'(0));
    chk("abort_out_valid", 512'(out_valid), 512'(0));
    chk("abort_vs1_bus", out_vs1_bus, 512'(0));
    chk("abort_vs2_bus", out_vs2_bus, 512'(0));
    chk("abort_nregs", 512'(out_nregs), 512'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("abort_recover_ready", 512'(req_ready), 512'(1));
    run_txn(5'd6, 5'd26, 5'd3, 2'b00, 1'b1, 1'b0, 32'd0, 0);

`ifdef VEC_OPC_VX_BCAST_EN
    run_txn(5'd10, 5'd14, 5'd4, 2'b01, 1'b0, 1'b1, 32'h0000_00A5, 2);
    run_txn(5'd10, 5'd29, 5'd4, 2'b10, 1'b1, 1'b1, 32'hDEAD_BEEF, 0);
`endif

    // Randomized transactions against the group-level reference
    for (int t = 0; t < 12; t++) begin
      logic vx_r;
      vx_r = 1'b0;
`ifdef VEC_OPC_VX_BCAST_EN
      vx_r = 1'($urandom);
`endif
      run_txn(5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom),
              vx_r, $urandom, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends with a summary
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
